fft_seq_ctrl: RTL and testbench

Top-level sequencer for the radix-2 DIT FFT datapath. It runs four phases in order:
- LOAD: accepts N samples and writes them to memory at bit-reversed addresses.
- PREP: releases the AGU from reset.
- COMPUTE: for each stage, issues exactly N/2 butterfly steps to the AGU, drains the butterfly pipeline, then swaps the ping-pong banks.
- UNLOAD: streams the results out in natural order.

It sits between the host stream interfaces, the DIT address generator, the butterfly pipeline and the two-bank sample memory.

---
 rtl/fft_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// Phase sequencer for the radix-2 DIT FFT: LOAD (bit-reversed writes), PREP, per-stage ISSUE/DRAIN/SWAP, UNLOAD.
// Optional macro FFT_CTRL_PERF_EN adds perf_cycles, a saturating count of busy cycles since the last accepted start.
module fft_seq_ctrl #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N),
  parameter int BF_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            log2n,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  ld_we,
  output logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [ADDR_WIDTH:0]   n_cfg,
  output logic                  agu_rst_n,
  output logic                  agu_next_step,
  input  logic                  agu_done_stage,
  input  logic                  agu_done_fft,
  output logic                  bf_rd_en,
  output logic                  bf_wr_en,
  output logic                  bank_sel,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef FFT_CTRL_PERF_EN
  output logic [15:0]           perf_cycles,
`endif
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, PREP = 3'd2, ISSUE = 3'd3,
    DRAIN = 3'd4, SWAP = 3'd5, UNLOAD = 3'd6
  } state_t;

  state_t                state, state_n;
  logic [2:0]            log2n_q;
  logic [ADDR_WIDTH-1:0] load_cnt, bf_cnt, unload_cnt, rev_full;
  logic [2:0]            stage;
  logic                  stage_seen;
  logic [BF_LATENCY-1:0] dly, dly_nxt;
  logic [ADDR_WIDTH:0]   n_m1, half_m1;
  logic                  start_ok, load_last, bf_last, stage_last, unload_last, drain_empty;

  // Handshakes: a transfer happens in any cycle where valid and ready are both high;
  // valid never waits on ready, and the payload (rd_addr, m_last) is held until it transfers.
  assign s_ready       = (state == LOAD);
  assign ld_we         = s_valid & s_ready;
  assign bf_rd_en      = (state == ISSUE);
  assign agu_next_step = bf_rd_en;
  assign m_valid       = (state == UNLOAD);
  assign busy          = (state != IDLE);
  assign state_dbg     = state;
  assign rd_addr       = unload_cnt;
  assign bf_wr_en      = dly[BF_LATENCY-1];

  assign n_m1        = n_cfg - 1'b1;
  assign half_m1     = (n_cfg >> 1) - 1'b1;
  assign start_ok    = (log2n != 3'd0) && (int'(log2n) <= ADDR_WIDTH);
  assign load_last   = ({1'b0, load_cnt} == n_m1);
  assign bf_last     = ({1'b0, bf_cnt} == half_m1);
  assign stage_last  = (stage == log2n_q - 3'd1);
  assign unload_last = ({1'b0, unload_cnt} == n_m1);
  assign m_last      = m_valid && unload_last;

  // Full-width reversal, then shift down so only the low log2n bits survive.
  always_comb begin
    rev_full = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) rev_full[i] = load_cnt[ADDR_WIDTH-1-i];
  end
  assign ld_addr = s_ready ? (rev_full >> (3'(ADDR_WIDTH) - log2n_q)) : '0;

  if (BF_LATENCY == 1) begin : g_lat1
    assign dly_nxt = bf_rd_en;
  end else begin : g_latn
    assign dly_nxt = {dly[BF_LATENCY-2:0], bf_rd_en};
  end
  assign drain_empty = (dly_nxt == '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && start_ok) state_n = LOAD;
      LOAD:    if (ld_we && load_last) state_n = PREP;
      PREP:    state_n = ISSUE;
      ISSUE:   if (bf_last) state_n = DRAIN;
      DRAIN:   if (drain_empty) state_n = SWAP;
      SWAP:    state_n = stage_last ? UNLOAD : ISSUE;
      UNLOAD:  if (m_ready && unload_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      log2n_q    <= '0;
      n_cfg      <= '0;
      load_cnt   <= '0;
      bf_cnt     <= '0;
      unload_cnt <= '0;
      stage      <= '0;
      stage_seen <= 1'b0;
      dly        <= '0;
      bank_sel   <= 1'b0;
      agu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state     <= state_n;
      dly       <= dly_nxt;
      agu_rst_n <= (state_n == PREP) || (state_n == ISSUE) || (state_n == DRAIN) || (state_n == SWAP);
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start && start_ok) begin
            log2n_q  <= log2n;
            n_cfg    <= (ADDR_WIDTH+1)'(1) << log2n;
            load_cnt <= '0;
            err      <= 1'b0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LOAD: if (ld_we) load_cnt <= load_last ? '0 : load_cnt + ADDR_WIDTH'(1);
        PREP: begin
          bank_sel   <= 1'b0;
          stage      <= '0;
          stage_seen <= 1'b0;
          bf_cnt     <= '0;
        end
        ISSUE: begin
          bf_cnt     <= bf_last ? '0 : bf_cnt + ADDR_WIDTH'(1);
          stage_seen <= stage_seen | agu_done_stage;
        end
        DRAIN: stage_seen <= stage_seen | agu_done_stage;
        SWAP: begin
          bank_sel <= ~bank_sel;
          if (!stage_seen) err <= 1'b1;
          if (!stage_last) begin
            stage      <= stage + 3'd1;
            stage_seen <= 1'b0;
          end else begin
            if (!agu_done_fft) err <= 1'b1;
            unload_cnt <= '0;
          end
        end
        UNLOAD: begin
          if (m_ready) begin
            unload_cnt <= unload_last ? '0 : unload_cnt + ADDR_WIDTH'(1);
            done       <= unload_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 perf_cycles <= '0;
    else if (state == IDLE && start && start_ok) perf_cycles <= '0;
    else if (busy && perf_cycles != 16'hFFFF)   perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl with a behavioural AGU model and hand-computed expectations.
module tb_fft_seq_ctrl;
  localparam int AW = 5;
  localparam logic [2:0] S_IDLE = 3'd0, S_PREP = 3'd2, S_DRAIN = 3'd4, S_SWAP = 3'd5, S_UNLOAD = 3'd6;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [2:0] log2n = 3'd0;
  logic s_ready, ld_we, agu_rst_n, agu_next_step, bf_rd_en, bf_wr_en, bank_sel;
  logic m_valid, m_last, busy, done, err;
  logic agu_done_stage, agu_done_fft;
  logic [AW-1:0] ld_addr, rd_addr;
  logic [AW:0] n_cfg;
  logic [2:0] state_dbg;
`ifdef FFT_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_vec = 0, n_err = 0;
  int rev8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int rev4[4] = '{0, 2, 1, 3};
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [AW-1:0] exp_q[$];
  int model_l2n = 3, suppress_stage = -1, agu_step, agu_stage;
  logic [27:0] outs;

  assign outs = {s_ready, ld_we, ld_addr, n_cfg, agu_rst_n, agu_next_step, bf_rd_en, bf_wr_en,
                 bank_sel, m_valid, rd_addr, m_last, busy, done, err};

  fft_seq_ctrl #(.MAX_N(32), .BF_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .log2n(log2n), .s_valid(s_valid), .s_ready(s_ready),
    .ld_we(ld_we), .ld_addr(ld_addr), .n_cfg(n_cfg), .agu_rst_n(agu_rst_n),
    .agu_next_step(agu_next_step), .agu_done_stage(agu_done_stage), .agu_done_fft(agu_done_fft),
    .bf_rd_en(bf_rd_en), .bf_wr_en(bf_wr_en), .bank_sel(bank_sel), .m_valid(m_valid),
    .m_ready(m_ready), .rd_addr(rd_addr), .m_last(m_last), .busy(busy), .done(done), .err(err),
`ifdef FFT_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // AGU model: one done_stage pulse after every N/2 steps, done_fft level after the last stage
  always @(posedge clk or negedge reset) begin
    if (!reset || !agu_rst_n) begin
      agu_step <= 0; agu_stage <= 0; agu_done_stage <= 1'b0; agu_done_fft <= 1'b0;
    end else begin
      agu_done_stage <= 1'b0;
      if (agu_next_step) begin
        if (agu_step == (1 << model_l2n) / 2 - 1) begin
          agu_step       <= 0;
          agu_done_stage <= (agu_stage != suppress_stage);
          agu_stage      <= agu_stage + 1;
          if (agu_stage == model_l2n - 1) agu_done_fft <= 1'b1;
        end else begin
          agu_step <= agu_step + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a transform and streams N samples with s_valid held high.
  task automatic load_phase(input int l2n);
    int n = 1 << l2n;
    int a;
    start = 1'b1; log2n = 3'(l2n); s_valid = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || n_cfg !== 6'(n))
      begin n_err++; $display("FAIL start_accept: err=%b done=%b busy=%b n_cfg=%0d want 0 0 1 %0d", err, done, busy, n_cfg, n); end
    for (int i = 0; i < n; i++) begin
      a = (l2n == 3) ? rev8[i] : rev4[i];
      n_vec++;
      if (ld_we !== 1'b1 || s_ready !== 1'b1 || ld_addr !== a[AW-1:0])
        begin n_err++; $display("FAIL load[%0d]: ld_we=%b s_ready=%b ld_addr=%0d want 1 1 %0d", i, ld_we, s_ready, ld_addr, a); end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic compute_phase(input int l2n, input int bad_stage, input int abort_stage, input bit poke);
    int half = (1 << l2n) / 2;
    int wr = 0;
    logic exp_err = 1'b0;
    n_vec++;
    if (state_dbg !== S_PREP || agu_rst_n !== 1'b1 || s_ready !== 1'b0)
      begin n_err++; $display("FAIL prep: state=%0d agu_rst_n=%b s_ready=%b want 2 1 0", state_dbg, agu_rst_n, s_ready); end
    tick();
    for (int s = 0; s < l2n; s++) begin
      for (int k = 0; k < half; k++) begin
        n_vec++;
        if (bf_rd_en !== 1'b1 || agu_next_step !== 1'b1 || bank_sel !== s[0] || err !== exp_err)
          begin n_err++; $display("FAIL issue s%0d k%0d: rd=%b step=%b bank=%b err=%b want 1 1 %b %b", s, k, bf_rd_en, agu_next_step, bank_sel, err, s[0], exp_err); end
        wr += int'(bf_wr_en);
        if (poke && s == 0 && k == 0) begin start = 1'b1; log2n = 3'd2; end
        tick();
        start = 1'b0;
      end
      if (poke && s == 0) begin
        n_vec++;
        if (n_cfg !== 6'(2 * half) || state_dbg !== S_DRAIN)
          begin n_err++; $display("FAIL start_ignored: n_cfg=%0d state=%0d want %0d 4", n_cfg, state_dbg, 2 * half); end
      end
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (state_dbg !== S_DRAIN || bf_rd_en !== 1'b0)
          begin n_err++; $display("FAIL drain s%0d d%0d: state=%0d rd=%b want 4 0", s, d, state_dbg, bf_rd_en); end
        wr += int'(bf_wr_en);
        if (s == abort_stage) return;
        tick();
      end
      n_vec++;
      if (state_dbg !== S_SWAP || err !== exp_err)
        begin n_err++; $display("FAIL swap s%0d: state=%0d err=%b want 5 %b", s, state_dbg, err, exp_err); end
      wr += int'(bf_wr_en);
      tick();
      if (s == bad_stage) exp_err = 1'b1;
    end
    n_vec++;
    if (state_dbg !== S_UNLOAD || bank_sel !== l2n[0] || err !== exp_err || agu_rst_n !== 1'b0 || wr != l2n * half)
      begin n_err++; $display("FAIL compute_end: state=%0d bank=%b err=%b agu_rst_n=%b wr=%0d want 6 %b %b 0 %0d", state_dbg, bank_sel, err, agu_rst_n, wr, l2n[0], exp_err, l2n * half); end
  endtask

  // Drains N results through the scoreboard; ends on the done-pulse cycle.
  task automatic unload_phase(input int n, input bit bp);
    int cyc = 0;
    int dones = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(AW'(i));
    while (exp_q.size() != 0 && cyc < 64) begin
      m_ready = bp ? pat[cyc % 4] : 1'b1;
      n_vec++;
      if (m_valid !== 1'b1 || rd_addr !== exp_q[0] || m_last !== (exp_q.size() == 1))
        begin n_err++; $display("FAIL unload c%0d: valid=%b rd_addr=%0d last=%b want 1 %0d %b", cyc, m_valid, rd_addr, m_last, exp_q[0], exp_q.size() == 1); end
      if (done === 1'b1) dones++;
      if (m_ready) void'(exp_q.pop_front());
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL unload_timeout: %0d results left want 0", exp_q.size()); end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || dones != 0 || state_dbg !== S_IDLE)
      begin n_err++; $display("FAIL done_pulse: done=%b busy=%b valid=%b early=%0d want 1 0 0 0", done, busy, m_valid, dones); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_vec++;
    if (outs !== '0 || state_dbg !== S_IDLE)
      begin n_err++; $display("FAIL reset: outs=%h state=%0d want 0 0", outs, state_dbg); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_bad_start();
    start = 1'b1; log2n = 3'd0;
    tick();
    start = 1'b0;
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bad_start_0: err=%b busy=%b want 1 0", err, busy); end
    reset = 1'b0; tick(); reset = 1'b1; tick();
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL err_reset: err=%b want 0", err); end
    start = 1'b1; log2n = 3'd6;
    tick();
    start = 1'b0;
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bad_start_6: err=%b busy=%b want 1 0", err, busy); end
    tick();
  endtask

  task automatic test_full_run();
    model_l2n = 3;
    load_phase(3);
    compute_phase(3, -1, -1, 1'b0);
    unload_phase(8, 1'b0);
`ifdef FFT_CTRL_PERF_EN
    n_vec++;
    if (perf_cycles !== 16'd38) begin n_err++; $display("FAIL perf_cycles: got %0d want 38", perf_cycles); end
`endif
  endtask

  task automatic test_back_to_back_backpressure();
    load_phase(3);
    compute_phase(3, -1, -1, 1'b0);
    unload_phase(8, 1'b1);
  endtask

  task automatic test_stage_error();
    suppress_stage = 1;
    load_phase(3);
    compute_phase(3, 1, -1, 1'b0);
    unload_phase(8, 1'b0);
    suppress_stage = -1;
  endtask

  task automatic test_abort_and_restart();
    load_phase(3);
    compute_phase(3, -1, 2, 1'b1);
    n_vec++;
    if (busy !== 1'b1 || agu_rst_n !== 1'b1) begin n_err++; $display("FAIL pre_abort: busy=%b agu_rst_n=%b want 1 1", busy, agu_rst_n); end
    reset = 1'b0;
    #1;
    n_vec++;
    if (outs !== '0 || state_dbg !== S_IDLE)
      begin n_err++; $display("FAIL async_abort: outs=%h state=%0d want 0 0", outs, state_dbg); end
    tick(); tick();
    reset = 1'b1;
    tick();
    model_l2n = 2;
    load_phase(2);
    compute_phase(2, -1, -1, 1'b0);
    unload_phase(4, 1'b0);
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || bank_sel !== 1'b0)
      begin n_err++; $display("FAIL final_idle: done=%b busy=%b bank=%b want 0 0 0", done, busy, bank_sel); end
  endtask

  initial begin
    test_reset();
    test_bad_start();
    test_full_run();
    test_back_to_back_backpressure();
    test_stage_error();
    test_abort_and_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
